// File: rtl/phy_tx_seq.sv
// Transmit link sequencer: buffers upstream words, emits a COM training run,
// then forwards data with IDL fill when starved and after each maximum-length burst.
//   state | meaning
//   RST   | first cycle after reset, outputs quiet
//   TRAIN | sending TRAIN_WORDS COM words
//   IDLE  | link up, nothing queued, sending IDL
//   DATA  | link up, forwarding FIFO words
module phy_tx_seq #(
  parameter int         DEPTH       = 4,
  parameter int         TRAIN_WORDS = 8,
  parameter int         BURST_MAX   = 16,
  parameter logic [7:0] COM         = 8'hBC,
  parameter logic [7:0] IDL         = 8'h7C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic        retrain,
  output logic        ready,
  output logic [31:0] bus_out,
  output logic        bus_valid,
  output logic        link_up,
  output logic [1:0]  state_o,
  output logic        ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TRAIN_WORDS + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {S_RST = 2'd0, S_TRAIN = 2'd1, S_IDLE = 2'd2, S_DATA = 2'd3} state_t;

  state_t        state, nxt_state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic [31:0]   bus_nxt;
  logic          valid_nxt;
  logic          push, pop, fifo_nonempty;

  assign ready         = reset & (count != CW'(DEPTH));
  assign push          = data_valid & ready;
  assign fifo_nonempty = (count != '0);
  assign state_o       = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RST;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      S_RST:   nxt_state = S_TRAIN;
      S_TRAIN: if (retrain)                            nxt_state = S_TRAIN;
               else if (tcnt == TW'(TRAIN_WORDS - 1))  nxt_state = S_IDLE;
      S_IDLE:  if (retrain)            nxt_state = S_TRAIN;
               else if (fifo_nonempty) nxt_state = S_DATA;
      S_DATA:  if (retrain)             nxt_state = S_TRAIN;
               else if (!fifo_nonempty) nxt_state = S_IDLE;
      default: nxt_state = S_RST;
    endcase
  end

  // Retrain overrides every load/pop decision so the head word stays queued.
  always_comb begin
    bus_nxt   = bus_out;
    valid_nxt = bus_valid;
    tcnt_nxt  = tcnt;
    bcnt_nxt  = bcnt;
    pop       = 1'b0;
    if (state == S_RST) begin
      tcnt_nxt = '0;
      bcnt_nxt = '0;
    end else if (retrain) begin
      tcnt_nxt  = '0;
      bus_nxt   = {4{IDL}};
      valid_nxt = 1'b0;
    end else begin
      case (state)
        S_TRAIN: begin
          bus_nxt   = {4{COM}};
          valid_nxt = 1'b1;
          tcnt_nxt  = tcnt + 1'b1;
        end
        S_IDLE: begin
          if (fifo_nonempty) begin
            bus_nxt   = mem[rd_ptr];
            valid_nxt = 1'b1;
            pop       = 1'b1;
            bcnt_nxt  = BW'(1);
          end else begin
            bus_nxt   = {4{IDL}};
            valid_nxt = 1'b0;
          end
        end
        S_DATA: begin
          if (!fifo_nonempty) begin
            bus_nxt   = {4{IDL}};
            valid_nxt = 1'b0;
          end else if (bcnt == BW'(BURST_MAX)) begin
            bus_nxt   = {4{IDL}};
            valid_nxt = 1'b0;
            bcnt_nxt  = '0;
          end else begin
            bus_nxt   = mem[rd_ptr];
            valid_nxt = 1'b1;
            pop       = 1'b1;
            bcnt_nxt  = bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
      link_up   <= 1'b0;
      tcnt      <= '0;
      bcnt      <= '0;
      ovf       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      bus_out   <= bus_nxt;
      bus_valid <= valid_nxt;
      link_up   <= (nxt_state == S_IDLE) || (nxt_state == S_DATA);
      tcnt      <= tcnt_nxt;
      bcnt      <= bcnt_nxt;
      if (data_valid && !ready) ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_phy_tx_seq.sv
// Bench for phy_tx_seq: stimulus feeds a queue of accepted words, a monitor
// checks every emitted word against it plus training-run and burst-length rules.
module tb_phy_tx_seq;
  localparam int          DEPTH       = 4;
  localparam int          TRAIN_WORDS = 8;
  localparam int          BURST_MAX   = 16;
  localparam logic [31:0] COM_W       = 32'hBCBC_BCBC;
  localparam logic [31:0] IDL_W       = 32'h7C7C_7C7C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        retrain = 1'b0;
  logic        ready, bus_valid, link_up, ovf;
  logic [31:0] bus_out;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  bit          ovf_m;
  logic        s_rst, s_dv, s_rdy, s_rt;
  logic [31:0] s_din;

  phy_tx_seq dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .retrain(retrain), .ready(ready), .bus_out(bus_out), .bus_valid(bus_valid),
    .link_up(link_up), .state_o(state_o), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (!(state_o == 2'd2 && !bus_valid) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  // Monitor / reference model
  initial begin
    int com_run = 0;
    int data_run = 0;
    int cnt_before;
    bit prev_lu = 0;
    bit push;
    logic [31:0] exp_w;
    forever begin
      @(negedge clk);
      s_rst = reset; s_dv = data_valid; s_rdy = ready; s_rt = retrain; s_din = data_in;
      @(posedge clk);
      #2;
      if (!reset || !s_rst) begin
        exp_q.delete(); ovf_m = 0; com_run = 0; data_run = 0; prev_lu = 0;
        continue;
      end
      push = s_dv && s_rdy;
      if (push) exp_q.push_back(s_din);
      if (s_dv && !s_rdy) ovf_m = 1;
      cnt_before = exp_q.size() - (push ? 1 : 0);
      if (bus_valid) begin
        if (bus_out == COM_W) begin
          com_run++;
          data_run = 0;
        end else begin
          if (com_run > 0) begin
            check("train_len", com_run, TRAIN_WORDS);
            com_run = 0;
          end
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %h with no word queued", bus_out);
          end else begin
            exp_w = exp_q.pop_front();
            check("data_order", bus_out, exp_w);
          end
          data_run++;
          check("burst_le_max", 32'(data_run <= BURST_MAX), 32'd1);
        end
      end else begin
        if (com_run > 0) begin
          check("train_len", com_run, TRAIN_WORDS);
          com_run = 0;
        end
        if (link_up) check("idle_word", bus_out, IDL_W);
        if (link_up && prev_lu && !s_rt && cnt_before > 0)
          check("burst_before_idl", data_run, BURST_MAX);
        data_run = 0;
      end
      check("ready", ready, 32'(exp_q.size() != DEPTH));
      check("ovf", ovf, ovf_m);
      prev_lu = link_up;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seq = 0;
    #2 reset = 1'b0;
    #10;
    check("rst_bus_out", bus_out, 32'h0);
    check("rst_bus_valid", bus_valid, 1'b0);
    check("rst_link_up", link_up, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_state", state_o, 2'd0);

    // Training after reset release
    tick();
    reset = 1'b1;
    wait_idle("train1", n);
    check("train_cycles", n, TRAIN_WORDS + 2);
    check("post_train_bus", bus_out, IDL_W);
    check("post_train_link", link_up, 1'b1);
    check("post_train_state", state_o, 2'd2);

    // Three consecutive words
    data_valid = 1'b1; data_in = 32'h1111_1111; tick();
    data_in = 32'h2222_2222; tick();
    check("first_latency", bus_out, 32'h1111_1111);
    data_in = 32'h3333_3333; tick();
    data_valid = 1'b0;
    wait_idle("three_words", n);
    check("three_drained", exp_q.size(), 0);

    // Continuous feed exercising forced IDL slots
    for (int i = 0; i < 80; i++) begin
      data_valid = ready;
      data_in = 32'h5000_0000 + 32'(seq);
      tick();
      if (data_valid) seq++;
    end
    data_valid = 1'b0;
    wait_idle("burst", n);
    check("burst_drained", exp_q.size(), 0);

    // Overfill during training
    reset = 1'b0; tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_valid = 1'b1; data_in = 32'h0A00_0000 + 32'(i);
      tick();
      if (i == 3) check("full_ready", ready, 1'b0);
    end
    data_valid = 1'b0;
    check("full_ovf", ovf, 1'b1);
    wait_idle("overfill", n);
    check("overfill_drained", exp_q.size(), 0);

    // Retrain in DATA with words queued
    reset = 1'b0; tick();
    reset = 1'b1;
    wait_idle("train2", n);
    data_valid = 1'b1; data_in = 32'h0B00_0001; tick();
    data_in = 32'h0B00_0002; tick();
    check("pre_retrain_state", state_o, 2'd3);
    data_in = 32'h0B00_0003; retrain = 1'b1; tick();
    data_valid = 1'b0; retrain = 1'b0;
    check("retrain_state", state_o, 2'd1);
    wait_idle("retrain", n);
    check("retrain_drained", exp_q.size(), 0);

    // Random traffic with occasional retrain
    for (int i = 0; i < 400; i++) begin
      data_valid = 1'($urandom_range(0, 1));
      data_in    = $urandom & 32'h7FFF_FFFF;
      retrain    = link_up && ($urandom_range(0, 39) == 0);
      tick();
    end
    data_valid = 1'b0; retrain = 1'b0;
    wait_idle("random", n);
    check("random_drained", exp_q.size(), 0);

    // Asynchronous reset in DATA
    data_valid = 1'b1; data_in = 32'h0C00_0001; tick();
    data_in = 32'h0C00_0002; tick();
    check("pre_reset_state", state_o, 2'd3);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_bus_out", bus_out, 32'h0);
    check("mid_rst_bus_valid", bus_valid, 1'b0);
    check("mid_rst_link_up", link_up, 1'b0);
    check("mid_rst_state", state_o, 2'd0);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    data_valid = 1'b0;
    tick();
    reset = 1'b1;
    wait_idle("train3", n);
    check("reset_discard", exp_q.size(), 0);
    check("train3_bus", bus_out, IDL_W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
